// File: rtl/cal_hu_hls_dl_pkg.sv
// Shared types and helpers for the HLS deadlock report unit: FSM state
// encoding, process-index width and the lowest-set-bit priority function.
package cal_hu_hls_dl_pkg;

  localparam int PROC_NUM_DEF   = 4;
  localparam int PROC_NUM_MAX   = 32;
  localparam int PROC_ID_W      = $clog2(PROC_NUM_DEF);
  localparam int PROC_IDX_MAX_W = $clog2(PROC_NUM_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ORIGIN = 3'd1,
    S_TRACE  = 3'd2,
    S_REPORT = 3'd3,
    S_DONE   = 3'd4
  } dl_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [PROC_IDX_MAX_W-1:0] lowest_set(input logic [PROC_NUM_MAX-1:0] vec);
    lowest_set = '0;
    for (int i = PROC_NUM_MAX - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = PROC_IDX_MAX_W'(i);
    end
  endfunction

endpackage

// File: rtl/cal_hu_hls_dl_prio_enc.sv
// Lowest-index priority encoder over the per-process detect vector.
module cal_hu_hls_dl_prio_enc
  import cal_hu_hls_dl_pkg::*;
#(
  parameter int WIDTH = PROC_NUM_DEF
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [PROC_NUM_MAX-1:0] vec_ext;

  always_comb begin
    vec_ext            = '0;
    vec_ext[WIDTH-1:0] = vec;
  end

  assign idx   = IDX_W'(lowest_set(vec_ext));
  assign valid = |vec;

endmodule

// File: rtl/cal_hu_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process, traces the token around the
// wait cycle, and reports the participating processes once (closure or timeout).
module cal_hu_hls_deadlock_report_unit
  import cal_hu_hls_dl_pkg::*;
#(
  parameter int PROC_NUM    = PROC_NUM_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PROC_NUM-1:0]         dl_detect_vec,
  output logic                        dl_detect_out,
  output logic [PROC_NUM-1:0]         origin,
  output logic                        token_clear,
  output logic                        report_vld,
  output logic [$clog2(PROC_NUM)-1:0] report_origin_id,
  output logic [PROC_NUM-1:0]         report_mask,
  output logic                        report_timeout
);

  localparam int                 ID_W     = $clog2(PROC_NUM);
  localparam int                 CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  dl_state_e           state, state_nxt;
  logic [ID_W-1:0]     origin_id;
  logic [PROC_NUM-1:0] mask;
  logic [CNT_W-1:0]    cnt;

  logic [ID_W-1:0]     enc_idx;
  logic                enc_valid;
  logic                closure;
  logic                expired;

  cal_hu_hls_dl_prio_enc #(.WIDTH(PROC_NUM)) u_prio_enc (
    .vec   (dl_detect_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    // cnt == 0 marks the first TRACE cycle, where the origin bit is the token launch, not closure.
    closure   = (state == S_TRACE) && (cnt != '0) && dl_detect_vec[origin_id];
    expired   = (state == S_TRACE) && (cnt == CNT_LAST);
    case (state)
      S_IDLE:   if (enc_valid) state_nxt = S_ORIGIN;
      S_ORIGIN: state_nxt = S_TRACE;
      S_TRACE:  if (closure || expired) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort in progress emits nothing.
  assign origin      = (reset && state == S_ORIGIN) ? (PROC_NUM'(1) << origin_id) : '0;
  assign token_clear = reset && closure;
  assign report_vld  = reset && (state == S_REPORT);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= S_IDLE;
      origin_id        <= '0;
      mask             <= '0;
      cnt              <= '0;
      dl_detect_out    <= 1'b0;
      report_origin_id <= '0;
      report_mask      <= '0;
      report_timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (enc_valid) begin
            origin_id     <= enc_idx;
            mask          <= PROC_NUM'(1) << enc_idx;
            dl_detect_out <= 1'b1;
          end
        end
        S_ORIGIN: cnt <= '0;
        S_TRACE: begin
          mask <= mask | dl_detect_vec;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (closure || expired) begin
            report_origin_id <= origin_id;
            report_mask      <= mask | dl_detect_vec;
            report_timeout   <= !closure;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_hu_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit with a report scoreboard.
module tb_cal_hu_hls_deadlock_report_unit;
  import cal_hu_hls_dl_pkg::*;

  localparam int PN = 4;
  localparam int TO = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [PN-1:0]     dl_detect_vec;
  logic              dl_detect_out;
  logic [PN-1:0]     origin;
  logic              token_clear;
  logic              report_vld;
  logic [PROC_ID_W-1:0] report_origin_id;
  logic [PN-1:0]     report_mask;
  logic              report_timeout;

  typedef struct {
    logic [PROC_ID_W-1:0] id;
    logic [PN-1:0]        mask;
    logic                 tmo;
  } rpt_t;

  rpt_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_tc, n_org, n_rv;

  cal_hu_hls_deadlock_report_unit #(.PROC_NUM(PN), .TIMEOUT_CYC(TO)) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .dl_detect_out    (dl_detect_out),
    .origin           (origin),
    .token_clear      (token_clear),
    .report_vld       (report_vld),
    .report_origin_id (report_origin_id),
    .report_mask      (report_mask),
    .report_timeout   (report_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive on the falling edge, let combinational outputs settle.
  task automatic step(input logic [PN-1:0] vec, input logic rst = 1'b1);
    @(negedge clock);
    dl_detect_vec = vec;
    reset         = rst;
    #1;
    n_tc  += int'(token_clear);
    n_org += int'(origin != '0);
    n_rv  += int'(report_vld);
  endtask

  task automatic do_reset();
    step('0, 1'b0);
  endtask

  task automatic push_report(input logic [PROC_ID_W-1:0] id, input logic [PN-1:0] mask, input logic tmo);
    rpt_t e;
    e.id   = id;
    e.mask = mask;
    e.tmo  = tmo;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dl_out"}, 32'(dl_detect_out), 0);
    check({tag, "_origin"}, 32'(origin), 0);
    check({tag, "_token_clear"}, 32'(token_clear), 0);
    check({tag, "_report_vld"}, 32'(report_vld), 0);
    check({tag, "_report_id"}, 32'(report_origin_id), 0);
    check({tag, "_report_mask"}, 32'(report_mask), 0);
    check({tag, "_report_tmo"}, 32'(report_timeout), 0);
  endtask

  // Scoreboard: every report the DUT produces must match the oldest expectation.
  always @(negedge clock) begin
    #1;
    if (report_vld === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        rpt_t e;
        e = sb.pop_front();
        check("sb_id", 32'(report_origin_id), 32'(e.id));
        check("sb_mask", 32'(report_mask), 32'(e.mask));
        check("sb_timeout", 32'(report_timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    reset         = 1'b0;
    dl_detect_vec = '0;
    n_tc = 0; n_org = 0; n_rv = 0;

    // Reset state
    step('0, 1'b0);
    step('0, 1'b0);
    step('0);
    check_all_zero("reset");

    // Single detect: origin 2, closure on the fourth TRACE cycle
    step(4'b0100);
    check("single_origin_idle", 32'(origin), 0);
    check("single_dl_out_idle", 32'(dl_detect_out), 0);
    step(4'b0000);
    check("single_origin", 32'(origin), 32'b0100);
    check("single_dl_out", 32'(dl_detect_out), 1);
    step(4'b0000);
    check("single_origin_one_cycle", 32'(origin), 0);
    step(4'b0010);
    step(4'b0000);
    push_report(2'd2, 4'b0110, 1'b0);
    step(4'b0100);
    check("single_token_clear", 32'(token_clear), 1);
    step(4'b0000);
    check("single_report_vld", 32'(report_vld), 1);
    check("single_report_id", 32'(report_origin_id), 2);
    check("single_report_mask", 32'(report_mask), 32'b0110);
    check("single_report_tmo", 32'(report_timeout), 0);
    step(4'b0000);
    check("single_report_pulse", 32'(report_vld), 0);
    check("single_mask_hold", 32'(report_mask), 32'b0110);
    check("single_tc_after", 32'(token_clear), 0);

    // Simultaneous detects in the first post-reset cycle; origin bit in first TRACE is not closure
    do_reset();
    step(4'b1010);
    step(4'b0000);
    check("simul_origin", 32'(origin), 32'b0010);
    step(4'b0010);
    check("simul_first_trace_no_close", 32'(token_clear), 0);
    push_report(2'd1, 4'b0010, 1'b0);
    step(4'b0010);
    check("simul_token_clear", 32'(token_clear), 1);
    step(4'b0000);
    check("simul_report_vld", 32'(report_vld), 1);
    check("simul_mask_no_bit3", 32'(report_mask), 32'b0010);

    // Timeout: origin 0 never re-detects, process 3 joins
    do_reset();
    n_tc = 0;
    step(4'b0001);
    step(4'b0000);
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) push_report(2'd0, 4'b1001, 1'b1);
      step(i == 2 ? 4'b1000 : 4'b0000);
      check($sformatf("tmo_no_report_%0d", i), 32'(report_vld), 0);
    end
    step(4'b0000);
    check("tmo_report_vld", 32'(report_vld), 1);
    check("tmo_flag", 32'(report_timeout), 1);
    check("tmo_no_token_clear", 32'(n_tc), 0);

    // Closure on the last timeout cycle wins
    do_reset();
    step(4'b1000);
    step(4'b0000);
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) begin
        push_report(2'd3, 4'b1100, 1'b0);
        step(4'b1100);
        check("tie_token_clear", 32'(token_clear), 1);
      end else begin
        step(4'b0000);
      end
    end
    step(4'b0000);
    check("tie_report_vld", 32'(report_vld), 1);
    check("tie_timeout", 32'(report_timeout), 0);

    // Reset mid-TRACE aborts, then a new detection restarts cleanly
    do_reset();
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);
    step(4'b0100, 1'b0);
    check("abort_no_token_clear", 32'(token_clear), 0);
    step(4'b0001);
    check_all_zero("abort");
    step(4'b0000);
    check("restart_origin", 32'(origin), 32'b0001);
    step(4'b0000);
    push_report(2'd0, 4'b0001, 1'b0);
    step(4'b0001);
    check("restart_token_clear", 32'(token_clear), 1);
    step(4'b0000);
    check("restart_report_vld", 32'(report_vld), 1);

    // DONE is terminal
    n_tc = 0; n_org = 0; n_rv = 0;
    for (int i = 0; i < 100; i++) begin
      step(PN'($urandom_range(0, 15)));
    end
    check("done_no_origin", 32'(n_org), 0);
    check("done_no_token_clear", 32'(n_tc), 0);
    check("done_no_report", 32'(n_rv), 0);
    check("done_dl_out_sticky", 32'(dl_detect_out), 1);

    step(4'b0000);
    check("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_hu_hls_deadlock_report_unit.md
CAL_HU_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: cal_hu_hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4, meaning the number of monitored processes (2..32).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of TRACE cycles before abort (1..65535).
REQ-003 SHALL have port clock, input, 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1: the reset, which is synchronous and active-low.
REQ-005 SHALL have port dl_detect_vec, input, PROC_NUM: the per-process dl_detect_out of each detect unit.
REQ-006 SHALL have port dl_detect_out, output, 1: the global detected flag, broadcast to every detect unit's dl_detect_in.
REQ-007 SHALL have port origin, output, PROC_NUM: a one-hot token-origin strobe, one bit per process.
REQ-008 SHALL have port token_clear, output, 1: a strobe that clears the circulating token.
REQ-009 SHALL have port report_vld, output, 1: a one-cycle pulse meaning the report fields are valid.
REQ-010 SHALL have port report_origin_id, output, $clog2(PROC_NUM): the index of the origin process.
REQ-011 SHALL have port report_mask, output, PROC_NUM: the processes that took part in the detected cycle.
REQ-012 SHALL have port report_timeout, output, 1: set when the report ended by timeout rather than by closure.

Function
REQ-013 SHALL implement the FSM states IDLE, ORIGIN, TRACE, REPORT, DONE.
REQ-014 IDLE: if |dl_detect_vec, SHALL capture origin_id = the lowest set index, set mask = that bit only, and go to ORIGIN next cycle.
REQ-015 dl_detect_out SHALL be a register: set on the IDLE->ORIGIN transition and held at 1 until reset (sticky).
REQ-016 ORIGIN: SHALL drive origin = 1<<origin_id for exactly one cycle, clear the timeout counter, and go to TRACE.
REQ-017 TRACE: each cycle, SHALL OR dl_detect_vec into mask, except that the origin bit is not treated as closure in the first TRACE cycle.
REQ-018 TRACE: from the second TRACE cycle on, dl_detect_vec[origin_id]=1 SHALL mean closure: drive token_clear=1 combinationally in that same cycle and go to REPORT.
REQ-019 TRACE: the counter SHALL increment each cycle; when it reaches TIMEOUT_CYC-1 without closure, the block SHALL set timeout_flag and go to REPORT, with no token_clear.
REQ-020 If closure and timeout occur in the same cycle, closure SHALL win (token_clear=1, report_timeout=0).
REQ-021 REPORT: SHALL assert report_vld for one cycle with the registered origin_id, mask and timeout_flag, then go to DONE.
REQ-022 DONE: SHALL be terminal until reset; dl_detect_vec SHALL be ignored and no further origin, token_clear or report SHALL be issued.
REQ-023 Outside their stated cycles, origin, token_clear and report_vld SHALL be 0.
REQ-024 report_* fields SHALL hold their values after report_vld until reset.
REQ-025 The counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide and SHALL saturate, never wrapping.

Reset
REQ-026 When reset=0 at a clock edge, the block SHALL go to IDLE with dl_detect_out=0, origin=0, token_clear=0, report_vld=0, report_origin_id=0, report_mask=0, report_timeout=0, and counter=0.
REQ-027 Reset asserted in any state, including mid-TRACE, SHALL abort without emitting token_clear or a report.
REQ-028 The first post-reset cycle SHALL be able to accept a detection.

Structure
REQ-029 The state enum, PROC_ID_W = $clog2(PROC_NUM), and a lowest-set-bit priority function SHALL live in the shared package cal_hu_hls_dl_pkg.
REQ-030 The block SHALL have one sub-module, cal_hu_hls_dl_prio_enc (PROC_NUM-wide lowest-index priority encoder with a valid output).
REQ-031 No combinational path SHALL run from dl_detect_vec to any output except token_clear.

Verification
REQ-032 Single detect: PROC_NUM=4; dl_detect_vec=0100 for 1 cycle, then 0010 at T+3, then 0100 at T+5 -> origin=0100 at T+1, token_clear at T+5, report_vld at T+6 with id=2, mask=0110, timeout=0.
REQ-033 Simultaneous detects: dl_detect_vec=1010 in IDLE -> origin_id=1, origin=0010, mask starts at 0010 (bit 3 not latched).
REQ-034 Timeout: TIMEOUT_CYC=8, origin never re-detects -> report_vld exactly 8 cycles after the first TRACE cycle, timeout=1, and token_clear never asserted.
REQ-035 Tie: closure on the last timeout cycle -> token_clear=1 and report_timeout=0.
REQ-036 Reset mid-TRACE -> next cycle all outputs are 0, and a new detection restarts cleanly with the correct origin.
REQ-037 Post-DONE: dl_detect_vec toggled randomly for 100 cycles -> no origin, token_clear or report_vld, and dl_detect_out stays 1.
